// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 LCD read and write paths:
// FSM state encoding, read-mode codes and default bus timing.
package lcd_pkg;

  localparam int unsigned LCD_SETUP_CYC   = 3;
  localparam int unsigned LCD_EN_HIGH_CYC = 25;
  localparam int unsigned LCD_HOLD_CYC    = 2;
  localparam int unsigned LCD_GAP_CYC     = 25;
  localparam int unsigned LCD_MAX_POLLS   = 4096;

  localparam int unsigned PHASE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HIGH,
    ST_HOLD,
    ST_GAP,
    ST_FINISH
  } rd_state_e;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_STATUS = 2'b00;
  localparam mode_t MODE_POLL   = 2'b01;
  localparam mode_t MODE_DATA   = 2'b10;

  // The unused code 11 folds onto a plain status read.
  function automatic mode_t normalize_mode(input mode_t m);
    return (m == 2'b11) ? MODE_STATUS : m;
  endfunction

  function automatic logic [PHASE_W-1:0] phase_load(input int unsigned cyc);
    return PHASE_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by every timed phase of an LCD bus cycle;
// o_tc marks the last cycle of the loaded phase.
module lcd_phase_timer
  import lcd_pkg::*;
#(
  parameter int unsigned W = PHASE_W
) (
  input  logic         clock50,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock50 or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 read-side engine: status read, busy-flag polling and data read.
// Owns the LCD pins only while active is high; never drives the data bus.
module lcd_status_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = LCD_SETUP_CYC,
  parameter int unsigned EN_HIGH_CYC = LCD_EN_HIGH_CYC,
  parameter int unsigned HOLD_CYC    = LCD_HOLD_CYC,
  parameter int unsigned GAP_CYC     = LCD_GAP_CYC,
  parameter int unsigned MAX_POLLS   = LCD_MAX_POLLS
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       ready,
  output logic       done,
  output logic       busy_flag,
  output logic [6:0] addr_counter,
  output logic [7:0] read_data,
  output logic       timeout,
  output logic       active,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_data_oe,
  input  logic [7:0] lcd_data_in
);

  localparam int unsigned POLL_W = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);

  rd_state_e           r_state;
  mode_t               r_mode;
  logic [POLL_W-1:0]   r_poll_cnt;
  logic                r_ready;
  logic                r_done;
  logic                r_busy_flag;
  logic [6:0]          r_addr_counter;
  logic [7:0]          r_read_data;
  logic                r_timeout;
  logic                r_active;
  logic                r_rs;
  logic                r_rw;
  logic                r_en;

  logic                w_tc;
  logic                w_load;
  logic [PHASE_W-1:0]  w_load_val;
  logic                w_hold_to_gap;
  mode_t               w_mode_in;

  assign w_mode_in     = normalize_mode(mode);
  assign w_hold_to_gap = (r_mode == MODE_POLL) && r_busy_flag && (r_poll_cnt != POLL_LAST);

  // The timer is reloaded on the same edge the FSM changes phase, so each
  // phase lasts exactly its configured number of cycles.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load     = 1'b1;
          w_load_val = phase_load(SETUP_CYC);
        end
      end
      ST_SETUP: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = phase_load(EN_HIGH_CYC);
        end
      end
      ST_EN_HIGH: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = phase_load(HOLD_CYC);
        end
      end
      ST_HOLD: begin
        if (w_tc && w_hold_to_gap) begin
          w_load     = 1'b1;
          w_load_val = phase_load(GAP_CYC);
        end
      end
      ST_GAP: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = phase_load(SETUP_CYC);
        end
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  lcd_phase_timer #(
    .W (PHASE_W)
  ) u_timer (
    .clock50 (clock50),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clock50 or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_mode         <= MODE_STATUS;
      r_poll_cnt     <= '0;
      r_ready        <= 1'b1;
      r_done         <= 1'b0;
      r_busy_flag    <= 1'b0;
      r_addr_counter <= '0;
      r_read_data    <= '0;
      r_timeout      <= 1'b0;
      r_active       <= 1'b0;
      r_rs           <= 1'b0;
      r_rw           <= 1'b0;
      r_en           <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode     <= w_mode_in;
            r_timeout  <= 1'b0;
            r_poll_cnt <= '0;
            r_rs       <= (w_mode_in == MODE_DATA);
            r_rw       <= 1'b1;
            r_active   <= 1'b1;
            r_ready    <= 1'b0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tc) begin
            r_en    <= 1'b1;
            r_state <= ST_EN_HIGH;
          end
        end
        ST_EN_HIGH: begin
          if (w_tc) begin
            if (r_mode == MODE_DATA) begin
              r_read_data <= lcd_data_in;
            end else begin
              r_busy_flag    <= lcd_data_in[7];
              r_addr_counter <= lcd_data_in[6:0];
            end
            r_en    <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_tc) begin
            if (w_hold_to_gap) begin
              r_poll_cnt <= r_poll_cnt + POLL_W'(1);
              r_state    <= ST_GAP;
            end else begin
              // Still busy here means the poll budget is spent.
              if ((r_mode == MODE_POLL) && r_busy_flag) begin
                r_timeout <= 1'b1;
              end
              r_done   <= 1'b1;
              r_rw     <= 1'b0;
              r_rs     <= 1'b0;
              r_active <= 1'b0;
              r_state  <= ST_FINISH;
            end
          end
        end
        ST_GAP: begin
          if (w_tc) begin
            r_state <= ST_SETUP;
          end
        end
        ST_FINISH: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready        = r_ready;
  assign done         = r_done;
  assign busy_flag    = r_busy_flag;
  assign addr_counter = r_addr_counter;
  assign read_data    = r_read_data;
  assign timeout      = r_timeout;
  assign active       = r_active;
  assign lcd_rs       = r_rs;
  assign lcd_rw       = r_rw;
  assign lcd_en       = r_en;
  assign lcd_data_oe  = 1'b0;

endmodule
